// File: rtl/goal_pkg.sv
// -----------------------------------------------------------------------------
// goal_pkg
// Shared types and constants for the foosball goal/game-flow logic.
//   state_e      : main game-flow states of goal_controller
//   blink_cmd_e  : per-cycle command from goal_controller to frame_blinker
//   SCORE_W      : width of each player's score
//   FRAME_CNT_W  : width of the frame and blink counters
//   COORD_W      : width of the ball X/Y coordinates
//   Screen geometry (640x480) and the goal size it implies, used as the
//   default goal-mouth parameters.
//   sat_inc()    : score increment that saturates at a limit
// -----------------------------------------------------------------------------
package goal_pkg;

  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned COORD_W     = 11;

  // Default screen geometry; the goals are centred vertically on each edge.
  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned GOAL_DEPTH   = 20;
  localparam int unsigned GOAL_MOUTH_H = 100;

  typedef enum logic [2:0] {
    PLAY,
    SHOW,
    RESPAWN,
    ARM,
    OVER
  } state_e;

  // CLEAR: counters 0, sprite off.   START: counters 0, sprite on.
  // RUN  : count frames and blink.   HOLD : counters 0, sprite steady on.
  typedef enum logic [1:0] {
    BLINK_CLEAR,
    BLINK_START,
    BLINK_RUN,
    BLINK_HOLD
  } blink_cmd_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? lim : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_blinker.sv
// -----------------------------------------------------------------------------
// frame_blinker
// Frame-based timer for the GOAL celebration. Counts startOfFrame pulses while
// running, toggles the sprite phase every BLINK_FRAMES frames and flags the
// last frame of a SHOW_FRAMES-long celebration.
//   CLK, RESET    : clock, synchronous active-high reset
//   cmd           : what to do this cycle (clear / start / run / hold on)
//   startOfFrame  : one-cycle pulse per video frame
//   phase         : registered sprite enable (drives goal_ena directly)
//   done          : combinational; high on the startOfFrame that ends the
//                   celebration (frame_cnt == SHOW_FRAMES-1)
// -----------------------------------------------------------------------------
module frame_blinker
  import goal_pkg::*;
#(
  parameter int unsigned SHOW_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  blink_cmd_e cmd,
  input  logic       startOfFrame,
  output logic       phase,
  output logic       done
);

  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(SHOW_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] LAST_BLINK = FRAME_CNT_W'(BLINK_FRAMES - 1);

  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] blink_cnt;

  // Counters sit at zero outside a celebration, so done only matters while
  // the controller is showing; it ignores done in every other state.
  assign done = startOfFrame && (frame_cnt == LAST_FRAME);

  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values; blocking ones would make results order-dependent.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_cnt <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      case (cmd)
        BLINK_START: begin
          frame_cnt <= '0;
          blink_cnt <= '0;
          phase     <= 1'b1;
        end
        BLINK_RUN: begin
          if (startOfFrame) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            if (blink_cnt == LAST_BLINK) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + FRAME_CNT_W'(1);
            end
          end
        end
        BLINK_HOLD: begin
          frame_cnt <= '0;
          blink_cnt <= '0;
          phase     <= 1'b1;
        end
        default: begin
          frame_cnt <= '0;
          blink_cnt <= '0;
          phase     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/goal_controller.sv
// -----------------------------------------------------------------------------
// goal_controller
// Game-flow block for the foosball screen. Watches the ball at each frame
// start, scores goals, freezes play while the GOAL sprite blinks, then
// requests a ball respawn (or ends the match when a player reaches WIN_SCORE).
//   CLK, RESET    : clock, synchronous active-high reset
//   startOfFrame  : one-cycle pulse per VGA frame; ball is sampled only then
//   ball_X/ball_Y : ball top-left position
//   new_game      : one-cycle pulse; clears scores and respawns the ball
//   goal_ena      : GOAL sprite enable (blinks during the celebration)
//   freeze        : halts ball and rod motion
//   ball_reset    : one-cycle pulse; re-centre the ball
//   score_left/_right : player scores, saturating at WIN_SCORE
//   game_over     : a player has reached WIN_SCORE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module goal_controller
  import goal_pkg::*;
#(
  parameter int unsigned GOAL_LEFT_X   = GOAL_DEPTH,
  parameter int unsigned GOAL_RIGHT_X  = SCREEN_W - GOAL_DEPTH,
  parameter int unsigned GOAL_Y_TOP    = (SCREEN_H - GOAL_MOUTH_H) / 2,
  parameter int unsigned GOAL_Y_BOTTOM = (SCREEN_H + GOAL_MOUTH_H) / 2,
  parameter int unsigned SHOW_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned WIN_SCORE     = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] ball_X,
  input  logic [COORD_W-1:0] ball_Y,
  input  logic               new_game,
  output logic               goal_ena,
  output logic               freeze,
  output logic               ball_reset,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over
);

  localparam logic [COORD_W-1:0] LEFT_X = COORD_W'(GOAL_LEFT_X);
  localparam logic [COORD_W-1:0] RIGHT_X = COORD_W'(GOAL_RIGHT_X);
  localparam logic [COORD_W-1:0] Y_TOP = COORD_W'(GOAL_Y_TOP);
  localparam logic [COORD_W-1:0] Y_BOTTOM = COORD_W'(GOAL_Y_BOTTOM);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_e             state;
  state_e             state_next;
  logic [SCORE_W-1:0] score_left_next;
  logic [SCORE_W-1:0] score_right_next;
  logic               freeze_next;
  logic               ball_reset_next;
  logic               game_over_next;
  blink_cmd_e         blink_cmd;
  logic               blink_done;

  logic in_mouth_y;
  logic in_left;
  logic in_right;

  // Goal tests on the raw unsigned coordinates. The left test is checked
  // first in the FSM, so it wins if the parameters ever make both true.
  assign in_mouth_y = (ball_Y >= Y_TOP) && (ball_Y < Y_BOTTOM);
  assign in_left    = (ball_X < LEFT_X) && in_mouth_y;
  assign in_right   = (ball_X >= RIGHT_X) && in_mouth_y;

  frame_blinker #(
    .SHOW_FRAMES (SHOW_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blinker (
    .CLK         (CLK),
    .RESET       (RESET),
    .cmd         (blink_cmd),
    .startOfFrame(startOfFrame),
    .phase       (goal_ena),
    .done        (blink_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= PLAY;
      score_left  <= '0;
      score_right <= '0;
      freeze      <= 1'b0;
      ball_reset  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_next;
      score_left  <= score_left_next;
      score_right <= score_right_next;
      freeze      <= freeze_next;
      ball_reset  <= ball_reset_next;
      game_over   <= game_over_next;
    end
  end

  // NOTE: every signal below is given a default first, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    score_left_next  = score_left;
    score_right_next = score_right;

    if (new_game) begin
      // Overrides any goal seen in the same cycle.
      state_next       = RESPAWN;
      score_left_next  = '0;
      score_right_next = '0;
    end else begin
      case (state)
        PLAY: begin
          if (startOfFrame && in_left) begin
            score_right_next = sat_inc(score_right, WIN);
            state_next       = SHOW;
          end else if (startOfFrame && in_right) begin
            score_left_next = sat_inc(score_left, WIN);
            state_next      = SHOW;
          end
        end
        SHOW: begin
          if (blink_done) begin
            state_next = ((score_left == WIN) || (score_right == WIN)) ? OVER : RESPAWN;
          end
        end
        RESPAWN: state_next = ARM;
        // The first frame after a respawn is never scored: the ball position
        // may still be the stale in-goal one from before the re-centre.
        ARM: begin
          if (startOfFrame) begin
            state_next = PLAY;
          end
        end
        OVER: state_next = OVER;
        default: state_next = PLAY;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    freeze_next     = (state_next == SHOW) || (state_next == RESPAWN) || (state_next == OVER);
    ball_reset_next = (state_next == RESPAWN);
    game_over_next  = (state_next == OVER);

    case (state_next)
      SHOW:    blink_cmd = (state == SHOW) ? BLINK_RUN : BLINK_START;
      OVER:    blink_cmd = BLINK_HOLD;
      default: blink_cmd = BLINK_CLEAR;
    endcase
  end

endmodule
